// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared ALU control codes, op encodings and sequencer states
// Purpose: constants used by the ALU sequencer and anything decoding its ops.
// Ports: none (package).
package mips_alu_pkg;

    localparam int DATA_W_FIXED = 32;

    // ALU control codes understood by the external MIPS ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_F   = 4'b1111;

    // op_in encodings
    localparam logic [1:0] OP_SINGLE = 2'b00;
    localparam logic [1:0] OP_SLLV   = 2'b01;
    localparam logic [1:0] OP_SRLV   = 2'b10;
    localparam logic [1:0] OP_MUL    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SINGLE = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_M_ADD  = 3'd3,
        ST_M_SLL  = 3'd4,
        ST_M_SRL  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    function automatic logic is_legal_cntrl(input logic [3:0] c);
        return (c == ALU_AND) || (c == ALU_OR)  || (c == ALU_ADD) ||
               (c == ALU_SUB) || (c == ALU_SLT) || (c == ALU_SLL) ||
               (c == ALU_SRL) || (c == ALU_NOR) || (c == ALU_F);
    endfunction

endpackage

// File: rtl/mips_alu_sequencer.sv
// rtl/mips_alu_sequencer.sv - multi-cycle controller owning the single MIPS ALU port
// Purpose: passes single ALU ops through, builds SLLV/SRLV from shift-by-1 steps and
//          a 32-bit low-word multiply from add/sll/srl steps; registers every result.
// Ports:
//   clk_in, reset_n_in           clock, synchronous active-low reset
//   start_in, op_in, cntrl_in    request strobe, op select, ALU code for single ops
//   a_in, b_in, shamt_in         operands and shift amount
//   alu_cntrl_out/a_out/b_out    registered drive of the external ALU
//   alu_result_in, alu_zero_in   external ALU result and zero flag
//   busy_out, done_out           status; done_out pulses for one cycle
//   result_out, zero_out, err_out registered result, zero and error flags
module mips_alu_sequencer
    import mips_alu_pkg::*;
#(
    parameter int MUL_EN = 1,
    parameter int DATA_W = DATA_W_FIXED
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              start_in,
    input  logic [1:0]        op_in,
    input  logic [3:0]        cntrl_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [4:0]        shamt_in,
    output logic [3:0]        alu_cntrl_out,
    output logic [DATA_W-1:0] alu_a_out,
    output logic [DATA_W-1:0] alu_b_out,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic              alu_zero_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [DATA_W-1:0] result_out,
    output logic              zero_out,
    output logic              err_out
);

    state_t            state, state_next, first_st;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] acc, mc, mp;
    logic              imm_err;
    logic [DATA_W-1:0] imm_result;

    // State an accepted request enters; ST_DONE means it completes without using the ALU.
    always_comb begin
        first_st = ST_DONE;
        case (op_in)
            OP_SINGLE: first_st = is_legal_cntrl(cntrl_in) ? ST_SINGLE : ST_DONE;
            OP_SLLV,
            OP_SRLV:   first_st = (shamt_in == 5'd0) ? ST_DONE : ST_SHIFT;
            default: begin
                if (MUL_EN != 0 && b_in != '0)
                    first_st = b_in[0] ? ST_M_ADD : ST_M_SLL;
            end
        endcase
    end

    // Outcome of requests that finish immediately
    assign imm_err    = (op_in == OP_SINGLE) || (op_in == OP_MUL && MUL_EN == 0);
    assign imm_result = (op_in == OP_SLLV || op_in == OP_SRLV) ? b_in : '0;

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) state <= ST_IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE,
            ST_DONE:   state_next = start_in ? first_st : ST_IDLE;
            ST_SINGLE: state_next = ST_DONE;
            ST_SHIFT:  state_next = (cnt == 5'd1) ? ST_DONE : ST_SHIFT;
            ST_M_ADD:  state_next = ST_M_SLL;
            ST_M_SLL:  state_next = ST_M_SRL;
            ST_M_SRL: begin
                if (alu_zero_in)           state_next = ST_DONE;
                else if (alu_result_in[0]) state_next = ST_M_ADD;
                else                       state_next = ST_M_SLL;
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state != ST_IDLE) && (state != ST_DONE);
        done_out = (state == ST_DONE);
    end

    // ALU drive is registered and loaded for the state being entered, so it is stable for
    // the whole cycle and simply holds while idle. During shifts alu_b_out is the work word.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            cnt           <= '0;
            acc           <= '0;
            mc            <= '0;
            mp            <= '0;
            alu_cntrl_out <= ALU_AND;
            alu_a_out     <= '0;
            alu_b_out     <= '0;
            result_out    <= '0;
            zero_out      <= 1'b0;
            err_out       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE,
                ST_DONE: begin
                    if (start_in) begin
                        cnt <= shamt_in;
                        acc <= '0;
                        mc  <= a_in;
                        mp  <= b_in;
                        case (first_st)
                            ST_SINGLE: begin
                                alu_cntrl_out <= cntrl_in;
                                alu_a_out     <= a_in;
                                alu_b_out     <= b_in;
                            end
                            ST_SHIFT: begin
                                alu_cntrl_out <= (op_in == OP_SLLV) ? ALU_SLL : ALU_SRL;
                                alu_b_out     <= b_in;
                            end
                            ST_M_ADD: begin
                                alu_cntrl_out <= ALU_ADD;
                                alu_a_out     <= '0;
                                alu_b_out     <= a_in;
                            end
                            ST_M_SLL: begin
                                alu_cntrl_out <= ALU_SLL;
                                alu_b_out     <= a_in;
                            end
                            default: begin
                                result_out <= imm_result;
                                zero_out   <= (imm_result == '0);
                                err_out    <= imm_err;
                            end
                        endcase
                    end
                end
                ST_SINGLE: begin
                    result_out <= alu_result_in;
                    zero_out   <= (alu_result_in == '0);
                    err_out    <= 1'b0;
                end
                ST_SHIFT: begin
                    alu_b_out <= alu_result_in;
                    cnt       <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result_out <= alu_result_in;
                        zero_out   <= (alu_result_in == '0);
                        err_out    <= 1'b0;
                    end
                end
                ST_M_ADD: begin
                    acc           <= alu_result_in;
                    alu_cntrl_out <= ALU_SLL;
                    alu_b_out     <= mc;
                end
                ST_M_SLL: begin
                    mc            <= alu_result_in;
                    alu_cntrl_out <= ALU_SRL;
                    alu_b_out     <= mp;
                end
                ST_M_SRL: begin
                    mp <= alu_result_in;
                    if (alu_zero_in) begin
                        result_out <= acc;
                        zero_out   <= (acc == '0);
                        err_out    <= 1'b0;
                    end else if (alu_result_in[0]) begin
                        alu_cntrl_out <= ALU_ADD;
                        alu_a_out     <= acc;
                        alu_b_out     <= mc;
                    end else begin
                        alu_cntrl_out <= ALU_SLL;
                        alu_b_out     <= mc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_sequencer.sv
// tb/tb_mips_alu_sequencer.sv - self-checking bench for mips_alu_sequencer with a behavioural ALU
module tb_mips_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  cntrl;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic [3:0]  alu_cntrl;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        alu_zero;
    logic        busy, done, zero, err;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    mips_alu_sequencer dut (
        .clk_in(clk), .reset_n_in(reset_n), .start_in(start), .op_in(op),
        .cntrl_in(cntrl), .a_in(a), .b_in(b), .shamt_in(shamt),
        .alu_cntrl_out(alu_cntrl), .alu_a_out(alu_a), .alu_b_out(alu_b),
        .alu_result_in(alu_res), .alu_zero_in(alu_zero),
        .busy_out(busy), .done_out(done), .result_out(result),
        .zero_out(zero), .err_out(err)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return (x < y) ? 32'd1 : 32'd0;
            4'b1000: return y << 1;
            4'b1001: return y >> 1;
            4'b1100: return ~(x | y);
            4'b1111: return x ^ y;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_res  = alu_fn(alu_cntrl, alu_a, alu_b);
        alu_zero = (alu_res == 32'd0);
    end

    function automatic logic legal(input logic [3:0] c);
        return c inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hF};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; start is raised now and accepted at the next posedge.
    task automatic do_op(input logic [1:0] o, input logic [3:0] c, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] s, input bit hold);
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_lat, n, msb, pc;
        exp_err = 1'b0;
        case (o)
            2'b00: begin
                exp_err = !legal(c);
                exp_res = exp_err ? 32'd0 : alu_fn(c, x, y);
                exp_lat = exp_err ? 1 : 2;
            end
            2'b01, 2'b10: begin
                exp_res = (o == 2'b01) ? (y << s) : (y >> s);
                exp_lat = int'(s) + 1;
            end
            default: begin
                exp_res = x * y;
                msb = -1; pc = 0;
                for (int i = 0; i < 32; i++) if (y[i]) begin msb = i; pc++; end
                exp_lat = (y == 0) ? 1 : 2 * (msb + 1) + pc + 1;
            end
        endcase
        start = 1'b1; op = o; cntrl = c; a = x; b = y; shamt = s;
        @(negedge clk);
        if (!hold) start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            check_val("busy", {31'd0, busy}, 32'd1);
            check_val("result_held", result, last_res);
            if (hold) begin
                start = 1'b1; op = 2'($urandom); cntrl = 4'($urandom);
                a = $urandom; b = $urandom; shamt = 5'($urandom);
            end
            @(negedge clk);
            n++;
        end
        check_val("done_seen", {31'd0, done}, 32'd1);
        check_val("latency", n, exp_lat);
        check_val("busy_in_done", {31'd0, busy}, 32'd0);
        check_val("result", result, exp_res);
        check_val("zero", {31'd0, zero}, {31'd0, exp_res == 32'd0});
        check_val("err", {31'd0, err}, {31'd0, exp_err});
        last_res = exp_res;
    endtask

    task automatic check_reset_state();
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_zero_err", {30'd0, zero, err}, 32'd0);
        check_val("rst_alu_cntrl", {28'd0, alu_cntrl}, 32'd0);
        check_val("rst_alu_a", alu_a, 32'd0);
        check_val("rst_alu_b", alu_b, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = '0; cntrl = '0; a = '0; b = '0; shamt = '0;
        last_res = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset_n = 1'b1;
        @(negedge clk);

        do_op(2'b00, 4'b0010, 32'd7, 32'd5, 5'd0, 1'b0);
        do_op(2'b01, 4'b0000, 32'd0, 32'd1, 5'd31, 1'b0);
        do_op(2'b10, 4'b0000, 32'd0, 32'hF0, 5'd0, 1'b0);
        do_op(2'b11, 4'b0000, 32'd5, 32'd3, 5'd0, 1'b0);
        do_op(2'b11, 4'b0000, 32'h1_0000, 32'h1_0000, 5'd0, 1'b0);
        do_op(2'b11, 4'b0000, 32'd1, 32'h8000_0000, 5'd0, 1'b0);
        do_op(2'b00, 4'b0011, 32'd9, 32'd9, 5'd0, 1'b0);
        // start held through busy, then the next op begins straight from DONE
        do_op(2'b00, 4'b0110, 32'd100, 32'd23, 5'd0, 1'b1);
        do_op(2'b11, 4'b0000, 32'd12345, 32'd678, 5'd0, 1'b0);
        start = 1'b0;
        @(negedge clk);
        check_val("done_pulse", {31'd0, done}, 32'd0);

        // reset in the middle of a multiply
        start = 1'b1; op = 2'b11; a = 32'd1; b = 32'h8000_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_state();
        reset_n = 1'b1;
        last_res = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        do_op(2'b10, 4'b0000, 32'd0, 32'hDEAD_BEEF, 5'd4, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [1:0] ro;
            logic [31:0] rb;
            ro = 2'($urandom);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b0;
                @(negedge clk);
                check_val("done_pulse", {31'd0, done}, 32'd0);
            end
            do_op(ro, 4'($urandom_range(0, 15)), $urandom, rb, 5'($urandom), 1'($urandom_range(0, 1)));
        end
        start = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
